// File: rtl/reset_seq.sv
// Staged synchronous reset sequencer for one generated clock domain.
// Waits for a stable lock, releases core reset, then peripheral reset after a gap.
// Loss of lock from RUN re-asserts both resets and bumps a saturating loss counter.
module reset_seq #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned CNTW          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_locked,
  output logic            rst_core,
  output logic            rst_periph,
  output logic            ready,
  output logic            lock_lost,
  output logic [CNTW-1:0] loss_cnt
);

  localparam int unsigned MAX_SH = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAXC   = (MAX_SH > GAP_CYCLES) ? MAX_SH : GAP_CYCLES;
  localparam int unsigned CW     = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    GAP,
    RUN
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d, cnt_inc;
  logic            rst_core_d, rst_periph_d, ready_d, lock_lost_d;
  logic [CNTW-1:0] loss_cnt_d;

  assign cnt_inc = cnt + CW'(1);

  // Next-state, phase counter and next output values.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    lock_lost_d  = 1'b0;
    loss_cnt_d   = loss_cnt;
    rst_core_d   = 1'b1;
    rst_periph_d = 1'b1;
    ready_d      = 1'b0;

    unique case (state)
      WAIT_LOCK: begin
        if (clk_locked) begin
          if (STABLE_CYCLES == 1) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            state_d = STABLE;
            cnt_d   = CW'(1);
          end
        end
      end
      STABLE: begin
        if (!clk_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_inc == CW'(STABLE_CYCLES)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (!clk_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_inc == CW'(HOLD_CYCLES)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (!clk_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_inc == CW'(GAP_CYCLES)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        if (!clk_locked) begin
          state_d     = WAIT_LOCK;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
          if (loss_cnt != {CNTW{1'b1}}) begin
            loss_cnt_d = loss_cnt + CNTW'(1);
          end
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Reset outputs follow the state being entered, so they register with it.
    if (state_d == GAP || state_d == RUN) begin
      rst_core_d = 1'b0;
    end
    if (state_d == RUN) begin
      rst_periph_d = 1'b0;
      ready_d      = 1'b1;
    end
  end

  // State, counter and registered outputs; rst has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      rst_core   <= 1'b1;
      rst_periph <= 1'b1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      loss_cnt   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      rst_core   <= rst_core_d;
      rst_periph <= rst_periph_d;
      ready      <= ready_d;
      lock_lost  <= lock_lost_d;
      loss_cnt   <= loss_cnt_d;
    end
  end

endmodule
